// File: rtl/adxl_spi_responder.sv
// ADXL345-compatible SPI slave (mode 3) serving X/Y/Z samples through the real register map.
// All SPI pins are synchronised into sys_clk; edges are detected on the synchronised levels.
module adxl_spi_responder #(
    parameter logic [7:0]  DEVID       = 8'hE5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic        sample_valid,
    input  logic [15:0] x_sample,
    input  logic [15:0] y_sample,
    input  logic [15:0] z_sample,
    output logic        data_ready,
    output logic [7:0]  bw_rate,
    output logic [7:0]  power_ctl,
    output logic [7:0]  data_format,
    output logic        txn_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA
    } state_t;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic                   is_read_q, is_read_d;
    logic                   mb_q, mb_d;
    logic [5:0]             addr_q, addr_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   txn_done_q, txn_done_d;
    logic                   data_ready_q, data_ready_d;
    logic [7:0]             bw_rate_q, bw_rate_d;
    logic [7:0]             power_ctl_q, power_ctl_d;
    logic [7:0]             data_format_q, data_format_d;
    logic [47:0]            live_q, live_d;
    logic [47:0]            snap_q, snap_d;

    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [7:0] byte_in;
    logic [5:0] next_addr;
    logic       dr_set, dr_clr;

    function automatic logic [7:0] reg_read(
        input logic [5:0]  a,
        input logic [47:0] xyz,
        input logic [7:0]  bw,
        input logic [7:0]  pc,
        input logic [7:0]  df
    );
        logic [7:0] r;
        case (a)
            ADDR_DEVID:       r = DEVID;
            ADDR_BW_RATE:     r = bw;
            ADDR_POWER_CTL:   r = pc;
            ADDR_DATA_FORMAT: r = df;
            6'h32:            r = xyz[7:0];
            6'h33:            r = xyz[15:8];
            6'h34:            r = xyz[23:16];
            6'h35:            r = xyz[31:24];
            6'h36:            r = xyz[39:32];
            6'h37:            r = xyz[47:40];
            default:          r = '0;
        endcase
        return r;
    endfunction

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign byte_in   = {rx_shift_q[6:0], mosi_s};
    assign next_addr = mb_q ? addr_q + 6'd1 : addr_q;

    always_comb begin
        state_d       = state_q;
        sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_prev_d   = sclk_s;
        cs_prev_d     = cs_s;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        is_read_d     = is_read_q;
        mb_d          = mb_q;
        addr_d        = addr_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        txn_done_d    = 1'b0;
        bw_rate_d     = bw_rate_q;
        power_ctl_d   = power_ctl_q;
        data_format_d = data_format_q;
        live_d        = live_q;
        snap_d        = snap_q;
        dr_set        = 1'b0;
        dr_clr        = 1'b0;

        if (sample_valid) begin
            live_d = {z_sample, y_sample, x_sample};
            dr_set = power_ctl_q[3];
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_CMD;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '0;
                    miso_d     = 1'b0;
                    miso_oe_d  = 1'b1;
                end
            end
            default: begin
                if (cs_rise) begin
                    // Partial byte is dropped: no write, no data_ready clear.
                    state_d    = ST_IDLE;
                    miso_d     = 1'b0;
                    miso_oe_d  = 1'b0;
                    txn_done_d = (state_q == ST_DATA);
                end else if (sclk_rise) begin
                    rx_shift_d = byte_in;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == ST_CMD) begin
                            state_d   = ST_DATA;
                            is_read_d = byte_in[7];
                            mb_d      = byte_in[6];
                            addr_d    = byte_in[5:0];
                            // Snapshot takes the pre-update live value even if a sample lands now.
                            if (byte_in[7]) begin
                                snap_d     = live_q;
                                tx_shift_d = reg_read(byte_in[5:0], live_q, bw_rate_q,
                                                      power_ctl_q, data_format_q);
                            end else begin
                                tx_shift_d = '0;
                            end
                        end else begin
                            if (!is_read_q) begin
                                case (addr_q)
                                    ADDR_BW_RATE:     bw_rate_d     = byte_in;
                                    ADDR_POWER_CTL:   power_ctl_d   = byte_in;
                                    ADDR_DATA_FORMAT: data_format_d = byte_in;
                                    default:          ;
                                endcase
                                tx_shift_d = '0;
                            end else begin
                                dr_clr     = (addr_q >= ADDR_DATAX0) && (addr_q <= ADDR_DATAZ1);
                                tx_shift_d = reg_read(next_addr, snap_q, bw_rate_q,
                                                      power_ctl_q, data_format_q);
                            end
                            addr_d = next_addr;
                        end
                    end
                end else if (sclk_fall && state_q == ST_DATA) begin
                    miso_d     = tx_shift_q[7];
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
        endcase

        if (dr_set)      data_ready_d = 1'b1;
        else if (dr_clr) data_ready_d = 1'b0;
        else             data_ready_d = data_ready_q;
    end

    // Chip-select history resets "asserted" so a cs_n held low through reset is not seen as a fall.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sclk_sync_q   <= '1;
            cs_sync_q     <= '0;
            mosi_sync_q   <= '0;
            sclk_prev_q   <= 1'b1;
            cs_prev_q     <= 1'b0;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            is_read_q     <= 1'b0;
            mb_q          <= 1'b0;
            addr_q        <= '0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            txn_done_q    <= 1'b0;
            data_ready_q  <= 1'b0;
            bw_rate_q     <= 8'h0A;
            power_ctl_q   <= '0;
            data_format_q <= '0;
            live_q        <= '0;
            snap_q        <= '0;
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            cs_prev_q     <= cs_prev_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            is_read_q     <= is_read_d;
            mb_q          <= mb_d;
            addr_q        <= addr_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            txn_done_q    <= txn_done_d;
            data_ready_q  <= data_ready_d;
            bw_rate_q     <= bw_rate_d;
            power_ctl_q   <= power_ctl_d;
            data_format_q <= data_format_d;
            live_q        <= live_d;
            snap_q        <= snap_d;
        end
    end

    assign spi_miso    = miso_q & miso_oe_q;
    assign spi_miso_oe = miso_oe_q;
    assign data_ready  = data_ready_q;
    assign bw_rate     = bw_rate_q;
    assign power_ctl   = power_ctl_q;
    assign data_format = data_format_q;
    assign txn_done    = txn_done_q;

endmodule

// File: tb/tb_adxl_spi_responder.sv
// Directed bench for adxl_spi_responder: acts as a mode-3 SPI master and checks the register map.
module tb_adxl_spi_responder;

    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_sclk = 1'b1;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        sample_valid = 1'b0;
    logic [15:0] x_sample = '0;
    logic [15:0] y_sample = '0;
    logic [15:0] z_sample = '0;
    logic        data_ready;
    logic [7:0]  bw_rate;
    logic [7:0]  power_ctl;
    logic [7:0]  data_format;
    logic        txn_done;

    int total = 0;
    int bad = 0;
    int txn_cnt = 0;

    adxl_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .sample_valid(sample_valid),
        .x_sample(x_sample),
        .y_sample(y_sample),
        .z_sample(z_sample),
        .data_ready(data_ready),
        .bw_rate(bw_rate),
        .power_ctl(power_ctl),
        .data_format(data_format),
        .txn_done(txn_done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) if (txn_done) txn_cnt++;

    // SCLK period 160 ns = 16 sys_clk cycles; MISO sampled just before each rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            spi_sclk = 1'b0;
            spi_mosi = tx[i];
            #80;
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            #80;
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        #160;
    endtask

    task automatic cs_high();
        #160;
        spi_cs_n = 1'b1;
        #200;
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge sys_clk);
        x_sample = x;
        y_sample = y;
        z_sample = z;
        sample_valid = 1'b1;
        @(negedge sys_clk);
        sample_valid = 1'b0;
        #20;
    endtask

    task automatic test_reset();
        repeat (5) @(negedge sys_clk);
        reset = 1'b0;
        #40;
        total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
        total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL reset_dr got=%b exp=0", data_ready); end
        total++; if (txn_done !== 1'b0) begin bad++; $display("FAIL reset_txn got=%b exp=0", txn_done); end
        total++; if (power_ctl !== 8'h00) begin bad++; $display("FAIL reset_pc got=%h exp=00", power_ctl); end
        total++; if (data_format !== 8'h00) begin bad++; $display("FAIL reset_df got=%h exp=00", data_format); end
        total++; if (bw_rate !== 8'h0A) begin bad++; $display("FAIL reset_bw got=%h exp=0a", bw_rate); end
    endtask

    task automatic test_measure_off();
        pulse_sample(16'h1111, 16'h2222, 16'h3333);
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL measure_off_dr got=%b exp=0", data_ready); end
    endtask

    task automatic test_devid_read();
        logic [7:0] rx;
        int c0;
        c0 = txn_cnt;
        cs_low();
        total++; if (spi_miso_oe !== 1'b1) begin bad++; $display("FAIL devid_oe_on got=%b exp=1", spi_miso_oe); end
        spi_bits(8'h80, 8, rx);
        spi_bits(8'h00, 8, rx);
        total++; if (rx !== 8'hE5) begin bad++; $display("FAIL devid_data got=%h exp=e5", rx); end
        cs_high();
        total++; if (txn_cnt - c0 !== 1) begin bad++; $display("FAIL devid_txn got=%0d exp=1", txn_cnt - c0); end
        total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL devid_oe_off got=%b exp=0", spi_miso_oe); end
        total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL devid_miso_off got=%b exp=0", spi_miso); end
    endtask

    task automatic test_write();
        logic [7:0] rx;
        int c0;
        c0 = txn_cnt;
        cs_low();
        spi_bits(8'h2D, 8, rx);
        spi_bits(8'h08, 7, rx);
        total++; if (power_ctl !== 8'h00) begin bad++; $display("FAIL write_pc_early got=%h exp=00", power_ctl); end
        spi_bits(8'h00, 1, rx);
        total++; if (power_ctl !== 8'h08) begin bad++; $display("FAIL write_pc got=%h exp=08", power_ctl); end
        total++; if (bw_rate !== 8'h0A) begin bad++; $display("FAIL write_bw got=%h exp=0a", bw_rate); end
        cs_high();
        total++; if (txn_cnt - c0 !== 1) begin bad++; $display("FAIL write_txn got=%0d exp=1", txn_cnt - c0); end
    endtask

    task automatic test_sample_read();
        logic [7:0] rx;
        logic [7:0] exp_b [6];
        exp_b = '{8'h34, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h80};
        pulse_sample(16'h1234, 16'hFFFE, 16'h8000);
        total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL sample_dr_set got=%b exp=1", data_ready); end
        cs_low();
        spi_bits(8'hF2, 8, rx);
        for (int b = 0; b < 6; b++) begin
            if (b == 2) pulse_sample(16'h5555, 16'h1111, 16'h2222);
            spi_bits(8'h00, 8, rx);
            total++; if (rx !== exp_b[b]) begin bad++; $display("FAIL snap_byte%0d got=%h exp=%h", b, rx, exp_b[b]); end
        end
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL read_dr_clr got=%b exp=0", data_ready); end
        pulse_sample(16'h5555, 16'h1111, 16'h2222);
        cs_high();
        total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL resample_dr got=%b exp=1", data_ready); end
        cs_low();
        spi_bits(8'hF2, 8, rx);
        spi_bits(8'h00, 8, rx);
        total++; if (rx !== 8'h55) begin bad++; $display("FAIL reread_b0 got=%h exp=55", rx); end
        spi_bits(8'h00, 8, rx);
        total++; if (rx !== 8'h55) begin bad++; $display("FAIL reread_b1 got=%h exp=55", rx); end
        cs_high();
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL reread_dr got=%b exp=0", data_ready); end
    endtask

    task automatic test_partial_write();
        logic [7:0] rx;
        int c0;
        c0 = txn_cnt;
        cs_low();
        spi_bits(8'h31, 8, rx);
        spi_bits(8'hFF, 4, rx);
        cs_high();
        total++; if (data_format !== 8'h00) begin bad++; $display("FAIL partial_df got=%h exp=00", data_format); end
        total++; if (txn_cnt - c0 !== 1) begin bad++; $display("FAIL partial_txn got=%0d exp=1", txn_cnt - c0); end
    endtask

    task automatic test_mb_wrap();
        logic [7:0] rx;
        cs_low();
        spi_bits(8'hFF, 8, rx);
        spi_bits(8'h00, 8, rx);
        total++; if (rx !== 8'h00) begin bad++; $display("FAIL wrap_3f got=%h exp=00", rx); end
        spi_bits(8'h00, 8, rx);
        total++; if (rx !== 8'hE5) begin bad++; $display("FAIL wrap_00 got=%h exp=e5", rx); end
        cs_high();
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        int c0;
        cs_low();
        spi_bits(8'h80, 8, rx);
        spi_bits(8'h00, 3, rx);
        spi_sclk = 1'b0;
        @(negedge sys_clk);
        reset = 1'b1;
        repeat (4) @(negedge sys_clk);
        reset = 1'b0;
        #100;
        c0 = txn_cnt;
        total++; if (spi_miso_oe !== 1'b0) begin bad++; $display("FAIL rmid_oe got=%b exp=0", spi_miso_oe); end
        total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL rmid_miso got=%b exp=0", spi_miso); end
        total++; if (power_ctl !== 8'h00) begin bad++; $display("FAIL rmid_pc got=%h exp=00", power_ctl); end
        total++; if (bw_rate !== 8'h0A) begin bad++; $display("FAIL rmid_bw got=%h exp=0a", bw_rate); end
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL rmid_dr got=%b exp=0", data_ready); end
        spi_sclk = 1'b1;
        #100;
        spi_cs_n = 1'b1;
        #200;
        total++; if (txn_cnt - c0 !== 0) begin bad++; $display("FAIL rmid_txn got=%0d exp=0", txn_cnt - c0); end
        cs_low();
        spi_bits(8'h80, 8, rx);
        spi_bits(8'h00, 8, rx);
        total++; if (rx !== 8'hE5) begin bad++; $display("FAIL rmid_next got=%h exp=e5", rx); end
        cs_high();
        total++; if (txn_cnt - c0 !== 1) begin bad++; $display("FAIL rmid_next_txn got=%0d exp=1", txn_cnt - c0); end
    endtask

    initial begin
        test_reset();
        test_measure_off();
        test_devid_read();
        test_write();
        test_sample_read();
        test_partial_write();
        test_mb_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
